exec_retire_stage: RTL and testbench
====================================

# exec_retire_stage

Pipeline stage directly downstream of the arith_logic_unit, closing the execute stage. It captures the ALU result (`alu_dout`) and comparison flag (`alu_comp`) with the decoded destination and branch information. It retires each entry in order: it issues the register-file write and resolves conditional branches into a one-cycle PC redirect. A 2-entry skid buffer decouples the valid/ready handshake toward execute from write-back stalls.

## Interface
- `DATA_WIDTH`, 32, width of ALU result, PC and immediate
- `REG_ADDR_WIDTH`, 5, register-file address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `ex_valid`  in  1  execute presents an entry
- `ex_ready`  out  1  stage can accept an entry this cycle
- `ex_alu_dout`  in  DATA_WIDTH  ALU result
- `ex_alu_comp`  in  1  ALU comparison flag (eq)
- `ex_rd`  in  REG_ADDR_WIDTH  destination register
- `ex_rd_en`  in  1  entry writes `ex_rd`
- `ex_branch`  in  1  entry is a conditional branch
- `ex_branch_inv`  in  1  branch taken when `ex_alu_comp`==0 (BNE-type)
- `ex_pc`  in  DATA_WIDTH  PC of the entry
- `ex_imm`  in  DATA_WIDTH  sign-extended branch offset
- `wb_stall`  in  1  write-back cannot retire this cycle
- `rd_en`  out  1  register-file write strobe
- `rd`  out  REG_ADDR_WIDTH  write address
- `rd_din`  out  DATA_WIDTH  write data
- `redirect_valid`  out  1  one-cycle pulse: taken branch retired
- `redirect_pc`  out  DATA_WIDTH  branch target
- `retire_count`  out  64  retired-entry count (only with `COPPERV_RETIRE_COUNT_EN`)

## Operation
- Storage: a head register and a skid register. The occupancy FSM has three states: EMPTY, ONE (head only) and FULL (head+skid).
- Accept: `ex_valid && ex_ready`. `ex_ready` = state!=FULL && !kill, where kill = head retires as a taken branch this cycle.
- Retire: head valid && !`wb_stall`. Entries retire strictly in acceptance order.
- Transitions:
  - EMPTY+accept -> ONE.
  - ONE+accept+!retire -> FULL (new entry to skid).
  - ONE+accept+retire -> ONE (new entry to head).
  - ONE+retire -> EMPTY.
  - FULL+retire -> ONE (skid moves to head).
  - FULL never accepts.
- Outputs are combinational from the head and gated by retire:
  - `rd_en` = retire && head.rd_en && head.rd!=0. A write to x0 is suppressed but the entry still retires.
  - `rd` = head.rd, `rd_din` = head.alu_dout.
- Branch: taken = head.branch && (head.alu_comp ^ head.branch_inv).
  - `redirect_valid` = retire && taken.
  - `redirect_pc` = head.pc + head.imm, computed modulo 2^DATA_WIDTH (wrap, no overflow flag).
  - A not-taken branch produces no redirect and no write.
- Kill on taken-branch retire, all in the same cycle:
  - Any skid entry is discarded.
  - `ex_ready` is low, so no entry is accepted.
  - Next state is EMPTY.
- Reset (`rst`==0 at an edge), including mid-operation: state EMPTY, all entries dropped.
- Reset values: `ex_ready`=1 after reset; `rd_en`=0, `redirect_valid`=0, `rd`=0, `rd_din`=0, `redirect_pc`=0; `retire_count`=0.

## Timing
- Latency: an entry accepted at edge N is visible at the head during cycle N+1. `rd_en`/`redirect_valid` assert in cycle N+1 if `wb_stall`=0.
- Throughput: 1 entry/cycle with no stalls.
- Each extra `wb_stall` cycle holds the head and outputs stable, with `rd_en`/`redirect_valid` low.
- `ex_ready` depends on `wb_stall` combinationally only through kill. Upstream must not make `ex_valid` depend on `ex_ready`.
- Upstream holds `ex_*` stable while `ex_valid && !ex_ready`.
- `redirect_valid` is high for exactly the retire cycle; a held stall does not repeat it.

## Configuration
- `COPPERV_RETIRE_COUNT_EN` defined: adds the `retire_count` port, a 64-bit counter.
  - Increments by 1 on every retire, including x0 writes and branches.
  - Reset to 0; wraps at 2^64.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Single ADD: one entry with `ex_alu_dout`=0x0000_0005, `ex_rd`=3, `ex_rd_en`=1, `wb_stall`=0 -> cycle after accept: `rd_en`=1, `rd`=3, `rd_din`=5; next cycle `rd_en`=0.
- Back-to-back stream: 4 entries on consecutive cycles, `wb_stall`=0 -> 4 consecutive `rd_en` pulses in order; `ex_ready` stays 1.
- Stall fill: `wb_stall`=1 for 3 cycles while 3 entries are offered -> first two accepted, `ex_ready`=0 on the third. After release, retire in order; the third is accepted once FULL drains.
- Taken BEQ with skid full: head `ex_branch`=1, comp=1, pc=0x100, imm=0xFFFF_FFF0 -> `redirect_valid`=1, `redirect_pc`=0xF0. Skid entry discarded (no `rd_en`); `ex_ready`=0 that cycle.
- BNE not taken / x0 write: `ex_branch_inv`=1, comp=1 -> no redirect. Entry with `ex_rd`=0, `ex_rd_en`=1 -> `rd_en` stays 0; with the macro, `retire_count` increments by 2.
- Reset mid-operation: FULL with `wb_stall`=1, `rst`=0 for one edge -> all outputs 0, `ex_ready`=1, no stale retire after `rst`=1.

Source files
------------

// File: rtl/exec_retire_stage.sv
// Execute-closing retire stage: head+skid buffer, in-order register write and branch redirect.
// Latency 1 cycle accept-to-retire; wb_stall holds the head, ex_ready drops when FULL or on a taken-branch kill.
// Optional COPPERV_RETIRE_COUNT_EN adds a 64-bit retired-entry counter on port retire_count.
module exec_retire_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_alu_dout,
    input  logic                      ex_alu_comp,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_rd_en,
    input  logic                      ex_branch,
    input  logic                      ex_branch_inv,
    input  logic [DATA_WIDTH-1:0]     ex_pc,
    input  logic [DATA_WIDTH-1:0]     ex_imm,
    input  logic                      wb_stall,
    output logic                      rd_en,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]     rd_din,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc
`ifdef COPPERV_RETIRE_COUNT_EN
    ,
    output logic [63:0]               retire_count
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_dout;
        logic                      alu_comp;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      rd_en;
        logic                      branch;
        logic                      branch_inv;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     imm;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d, skid_q, skid_d, ex_entry;
    logic   retire, taken, kill, accept;

    assign ex_entry = '{alu_dout: ex_alu_dout, alu_comp: ex_alu_comp, rd: ex_rd,
                        rd_en: ex_rd_en, branch: ex_branch, branch_inv: ex_branch_inv,
                        pc: ex_pc, imm: ex_imm};

    assign retire   = (state_q != EMPTY) && !wb_stall;
    assign taken    = head_q.branch && (head_q.alu_comp ^ head_q.branch_inv);
    assign kill     = retire && taken;
    assign ex_ready = (state_q != FULL) && !kill;
    assign accept   = ex_valid && ex_ready;

    assign rd_en          = retire && head_q.rd_en && (head_q.rd != '0);
    assign rd             = head_q.rd;
    assign rd_din         = head_q.alu_dout;
    assign redirect_valid = kill;
    assign redirect_pc    = head_q.pc + head_q.imm;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = ex_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (kill) begin
                    state_d = EMPTY;
                end else if (accept && retire) begin
                    head_d  = ex_entry;
                end else if (accept) begin
                    skid_d  = ex_entry;
                    state_d = FULL;
                end else if (retire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // A taken branch at the head squashes the younger skid entry.
                if (kill) begin
                    state_d = EMPTY;
                end else if (retire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef COPPERV_RETIRE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_retire_stage.sv
// Directed bench for exec_retire_stage: inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_exec_retire_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_dout = '0;
    logic        ex_alu_comp = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_rd_en = 1'b0;
    logic        ex_branch = 1'b0;
    logic        ex_branch_inv = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_imm = '0;
    logic        wb_stall = 1'b0;
    logic        rd_en;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef COPPERV_RETIRE_COUNT_EN
    logic [63:0] retire_count;
    logic [63:0] count_base;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    exec_retire_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_dout    (ex_alu_dout),
        .ex_alu_comp    (ex_alu_comp),
        .ex_rd          (ex_rd),
        .ex_rd_en       (ex_rd_en),
        .ex_branch      (ex_branch),
        .ex_branch_inv  (ex_branch_inv),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .wb_stall       (wb_stall),
        .rd_en          (rd_en),
        .rd             (rd),
        .rd_din         (rd_din),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef COPPERV_RETIRE_COUNT_EN
        ,
        .retire_count   (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input logic [31:0] dout, input logic comp,
                       input logic [4:0] r, input logic ren, input logic br,
                       input logic inv, input logic [31:0] pc, input logic [31:0] imm);
        ex_valid      = v;
        ex_alu_dout   = dout;
        ex_alu_comp   = comp;
        ex_rd         = r;
        ex_rd_en      = ren;
        ex_branch     = br;
        ex_branch_inv = inv;
        ex_pc         = pc;
        ex_imm        = imm;
    endtask

    task automatic idle();
        put(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic alu_op(input logic [4:0] r, input logic [31:0] dout);
        put(1'b1, dout, 1'b0, r, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        cyc(); #1;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rd_din", rd_din, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
`ifdef COPPERV_RETIRE_COUNT_EN
        chk("rst_retire_count", retire_count, 0);
`endif
        rst = 1'b1;

        // Single ADD
        cyc(); alu_op(5'd3, 32'h5); #1;
        chk("add_ready", ex_ready, 1);
        cyc(); idle(); #1;
        chk("add_rd_en", rd_en, 1);
        chk("add_rd", rd, 3);
        chk("add_rd_din", rd_din, 5);
        cyc(); #1;
        chk("add_rd_en_after", rd_en, 0);

        // Back-to-back stream of 4
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i < 4) alu_op(5'(i + 4), 32'h10 + 32'(i));
            else idle();
            #1;
            if (i < 4) chk("stream_ready", ex_ready, 1);
            if (i > 0) begin
                chk("stream_rd_en", rd_en, 1);
                chk("stream_rd", rd, 64'(i + 3));
                chk("stream_rd_din", rd_din, 64'(32'h10 + 32'(i - 1)));
            end
        end
        cyc(); #1;
        chk("stream_rd_en_after", rd_en, 0);

        // Stall fill
        wb_stall = 1'b1;
        cyc(); alu_op(5'd10, 32'hA0); #1;
        chk("fill_ready0", ex_ready, 1);
        cyc(); alu_op(5'd11, 32'hA1); #1;
        chk("fill_ready1", ex_ready, 1);
        chk("fill_rd_en1", rd_en, 0);
        cyc(); alu_op(5'd12, 32'hA2); #1;
        chk("fill_ready2", ex_ready, 0);
        chk("fill_rd_en2", rd_en, 0);
        chk("fill_hold_rd", rd, 10);
        cyc(); wb_stall = 1'b0; #1;
        chk("drain_ready_full", ex_ready, 0);
        chk("drain_rd_en0", rd_en, 1);
        chk("drain_rd0", rd, 10);
        cyc(); #1;
        chk("drain_ready_one", ex_ready, 1);
        chk("drain_rd_en1", rd_en, 1);
        chk("drain_rd1", rd, 11);
        cyc(); idle(); #1;
        chk("drain_rd_en2", rd_en, 1);
        chk("drain_rd2", rd, 12);
        chk("drain_rd_din2", rd_din, 32'hA2);
        cyc(); #1;
        chk("drain_rd_en_after", rd_en, 0);

        // Taken BEQ with skid full
        wb_stall = 1'b1;
        cyc(); put(1'b1, 32'h0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFF0); #1;
        cyc(); alu_op(5'd20, 32'h55); #1;
        chk("beq_ready_stalled", ex_ready, 1);
        chk("beq_redirect_stalled", redirect_valid, 0);
        cyc(); wb_stall = 1'b0; alu_op(5'd21, 32'h66); #1;
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'hF0);
        chk("beq_kill_ready", ex_ready, 0);
        chk("beq_rd_en", rd_en, 0);
        cyc(); idle(); #1;
        chk("beq_redirect_once", redirect_valid, 0);
        chk("beq_skid_dropped", rd_en, 0);
        chk("beq_ready_after", ex_ready, 1);
        cyc(); #1;
        chk("beq_nothing_left", rd_en, 0);

        // BNE not taken, then x0 write, then BNE taken with wrapping target
`ifdef COPPERV_RETIRE_COUNT_EN
        count_base = retire_count;
`endif
        cyc(); put(1'b1, 32'h0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h8); #1;
        cyc(); alu_op(5'd0, 32'h77); #1;
        chk("bne_nt_redirect", redirect_valid, 0);
        chk("bne_nt_rd_en", rd_en, 0);
        chk("bne_nt_ready", ex_ready, 1);
        cyc(); put(1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h10); #1;
        chk("x0_rd_en", rd_en, 0);
        chk("x0_redirect", redirect_valid, 0);
        cyc(); idle(); #1;
`ifdef COPPERV_RETIRE_COUNT_EN
        chk("count_plus2", retire_count, count_base + 64'd2);
`endif
        chk("bne_t_redirect", redirect_valid, 1);
        chk("bne_t_pc_wrap", redirect_pc, 32'h0000_0008);
        cyc(); #1;
        chk("bne_t_once", redirect_valid, 0);

        // Reset mid-operation from FULL
        wb_stall = 1'b1;
        cyc(); alu_op(5'd5, 32'h50); #1;
        cyc(); alu_op(5'd6, 32'h60); #1;
        cyc(); idle(); #1;
        chk("pre_rst_full", ex_ready, 0);
        rst = 1'b0;
        cyc(); rst = 1'b1; #1;
        chk("mid_rst_ready", ex_ready, 1);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_rd_din", rd_din, 0);
        chk("mid_rst_redirect_pc", redirect_pc, 0);
`ifdef COPPERV_RETIRE_COUNT_EN
        chk("mid_rst_count", retire_count, 0);
`endif
        wb_stall = 1'b0;
        #1;
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_redirect", redirect_valid, 0);
        cyc(); #1;
        chk("no_stale_retire", rd_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
